// File: rtl/int_gen_pkg.sv
// Shared types and constants for the multi-channel interrupt stimulus generator.
package int_gen_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARMED,
    ST_WAIT,
    ST_FIRE,
    ST_REARM,
    ST_DONE
  } chan_state_t;

  localparam logic [31:0] ACK_ADDR_DEF = 32'h0000_7f20;
  localparam logic [31:0] PC_WORD_MASK = 32'hffff_fffc;

endpackage

// File: rtl/int_gen_chan.sv
// One interrupt channel: PC match, delay countdown, firing count and re-arm FSM.
module int_gen_chan
  import int_gen_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            cfg_we,
  input  logic [31:0]     cfg_pc,
  input  logic [DW-1:0]   cfg_delay,
  input  logic [CNTW-1:0] cfg_count,
  input  logic            cfg_pulse,
  input  logic [31:0]     macroscopic_pc,
  input  logic            ack_sel,
  output logic            fire_level,
  output logic            irq
);

  chan_state_t     state, state_nxt;
  logic [31:0]     pc_q;
  logic [DW-1:0]   delay_q, dcnt, dcnt_nxt;
  logic [CNTW-1:0] rem, rem_nxt;
  logic            pulse_q;
  logic            irq_q;
  logic            match;

  assign match      = (macroscopic_pc & PC_WORD_MASK) == (pc_q & PC_WORD_MASK);
  assign fire_level = (state == ST_FIRE) && !pulse_q;
  assign irq        = irq_q;

  // A config write takes priority over every transition, including an ack.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    rem_nxt   = rem;
    if (cfg_we) begin
      state_nxt = (cfg_count == '0) ? ST_OFF : ST_ARMED;
      dcnt_nxt  = '0;
      rem_nxt   = cfg_count;
    end else begin
      case (state)
        ST_ARMED: begin
          if (en && match) begin
            if (delay_q == '0) begin
              state_nxt = ST_FIRE;
            end else begin
              state_nxt = ST_WAIT;
              dcnt_nxt  = delay_q;
            end
          end
        end
        ST_WAIT: begin
          if (dcnt == DW'(1)) state_nxt = ST_FIRE;
          else                dcnt_nxt  = dcnt - DW'(1);
        end
        ST_FIRE: begin
          if (pulse_q || ack_sel) begin
            rem_nxt   = rem - CNTW'(1);
            state_nxt = (rem > CNTW'(1)) ? ST_REARM : ST_DONE;
          end
        end
        ST_REARM: begin
          if (!match) state_nxt = ST_ARMED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_OFF;
      dcnt    <= '0;
      rem     <= '0;
      irq_q   <= 1'b0;
      pc_q    <= '0;
      delay_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      rem   <= rem_nxt;
      irq_q <= (state_nxt == ST_FIRE);
      if (cfg_we) begin
        pc_q    <= cfg_pc;
        delay_q <= cfg_delay;
        pulse_q <= cfg_pulse;
      end
    end
  end

endmodule

// File: rtl/int_gen_multi.sv
// Multi-channel interrupt stimulus generator: NUM_CH channels plus a lowest-index ack arbiter.
module int_gen_multi
  import int_gen_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CW       = 2,
  parameter int          DW       = 8,
  parameter int          CNTW     = 4,
  parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [31:0]       cfg_pc,
  input  logic [DW-1:0]     cfg_delay,
  input  logic [CNTW-1:0]   cfg_count,
  input  logic              cfg_pulse,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic              interrupt,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              ack_valid,
  output logic [CW-1:0]     ack_ch
);

  logic [NUM_CH-1:0] cfg_we_ch;
  logic [NUM_CH-1:0] fire_level;
  logic [NUM_CH-1:0] ack_sel;
  logic              ack_hit;
  logic              found;
  logic              win_cfg;
  logic              ack_take;
  logic [CW-1:0]     win;

  assign ack_hit = (|m_int_byteen) &&
                   ((m_int_addr & PC_WORD_MASK) == (ACK_ADDR & PC_WORD_MASK));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we_ch[i] = cfg_we && (cfg_ch == CW'(i));

    int_gen_chan #(
      .DW   (DW),
      .CNTW (CNTW)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .cfg_we         (cfg_we_ch[i]),
      .cfg_pc         (cfg_pc),
      .cfg_delay      (cfg_delay),
      .cfg_count      (cfg_count),
      .cfg_pulse      (cfg_pulse),
      .macroscopic_pc (macroscopic_pc),
      .ack_sel        (ack_sel[i]),
      .fire_level     (fire_level[i]),
      .irq            (irq_vec[i])
    );
  end

  // Only channels already in level FIRE before this edge compete for the ack.
  always_comb begin
    ack_sel = '0;
    win     = '0;
    found   = 1'b0;
    win_cfg = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fire_level[i] && !found) begin
        found      = 1'b1;
        win        = CW'(i);
        win_cfg    = cfg_we_ch[i];
        ack_sel[i] = ack_hit;
      end
    end
  end

  assign ack_take  = ack_hit && found && !win_cfg;
  assign interrupt = |irq_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_valid <= 1'b0;
      ack_ch    <= '0;
    end else begin
      ack_valid <= ack_take;
      ack_ch    <= ack_take ? win : '0;
    end
  end

endmodule

// File: tb/tb_int_gen_multi.sv
// Bench for int_gen_multi: directed scenarios with literal checks plus randomized traffic vs a scheduled-event model.
module tb_int_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CW     = 2;
  localparam int DW     = 8;
  localparam int CNTW   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CW-1:0]     cfg_ch = '0;
  logic [31:0]       cfg_pc = '0;
  logic [DW-1:0]     cfg_delay = '0;
  logic [CNTW-1:0]   cfg_count = '0;
  logic              cfg_pulse = 1'b0;
  logic [31:0]       macroscopic_pc = '0;
  logic [31:0]       m_int_addr = '0;
  logic [3:0]        m_int_byteen = '0;
  logic              interrupt;
  logic [NUM_CH-1:0] irq_vec;
  logic              ack_valid;
  logic [CW-1:0]     ack_ch;

  int checks = 0;
  int errors = 0;

  int_gen_multi #(
    .NUM_CH   (NUM_CH),
    .CW       (CW),
    .DW       (DW),
    .CNTW     (CNTW),
    .ACK_ADDR (32'h0000_7f20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_pc         (cfg_pc),
    .cfg_delay      (cfg_delay),
    .cfg_count      (cfg_count),
    .cfg_pulse      (cfg_pulse),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .interrupt      (interrupt),
    .irq_vec        (irq_vec),
    .ack_valid      (ack_valid),
    .ack_ch         (ack_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: each channel is armed / scheduled-to-fire-at-cycle / firing /
  // awaiting-PC-release, with an absolute fire time instead of a countdown.
  logic [31:0] m_pc      [NUM_CH];
  int          m_delay   [NUM_CH];
  int          m_rem     [NUM_CH];
  int          m_fire_at [NUM_CH];
  bit          m_pulse   [NUM_CH];
  bit          m_armed   [NUM_CH];
  bit          m_pend    [NUM_CH];
  bit          m_rel     [NUM_CH];
  bit          m_irq     [NUM_CH];
  bit          m_pre     [NUM_CH];
  int          cyc = 0;
  bit          m_av = 0;
  int          m_ach = 0;
  bit          m_hit;
  bit          m_match;
  int          m_win;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pc[i] = '0; m_delay[i] = 0; m_rem[i] = 0; m_fire_at[i] = 0;
        m_pulse[i] = 0; m_armed[i] = 0; m_pend[i] = 0; m_rel[i] = 0; m_irq[i] = 0;
      end
      m_av  = 0;
      m_ach = 0;
    end else begin
      cyc++;
      m_hit = (m_int_byteen != 4'd0) && ((m_int_addr & ~32'd3) == 32'h7f20);
      m_win = -1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_pre[i] = m_irq[i];
        if (m_win < 0 && m_irq[i] && !m_pulse[i]) m_win = i;
      end
      m_av  = 0;
      m_ach = 0;
      if (m_hit && m_win >= 0 && !(cfg_we && int'(cfg_ch) == m_win)) begin
        m_av  = 1;
        m_ach = m_win;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        m_match = (macroscopic_pc & ~32'd3) == (m_pc[i] & ~32'd3);
        if (cfg_we && int'(cfg_ch) == i) begin
          m_pc[i] = cfg_pc; m_delay[i] = int'(cfg_delay); m_pulse[i] = cfg_pulse;
          m_rem[i] = int'(cfg_count); m_armed[i] = (cfg_count != 0);
          m_pend[i] = 0; m_rel[i] = 0; m_irq[i] = 0;
        end else if (m_pre[i]) begin
          if (m_pulse[i] || (m_av && m_ach == i)) begin
            m_irq[i] = 0;
            m_rem[i] = m_rem[i] - 1;
            m_rel[i] = (m_rem[i] > 0);
          end
        end else if (m_pend[i]) begin
          if (cyc == m_fire_at[i]) begin
            m_pend[i] = 0;
            m_irq[i]  = 1;
          end
        end else if (m_rel[i]) begin
          if (!m_match) begin
            m_rel[i]   = 0;
            m_armed[i] = 1;
          end
        end else if (m_armed[i] && en && m_match) begin
          m_armed[i] = 0;
          if (m_delay[i] == 0) m_irq[i] = 1;
          else begin
            m_pend[i]    = 1;
            m_fire_at[i] = cyc + m_delay[i];
          end
        end
      end
    end
  end

  logic [NUM_CH-1:0] exp_vec;
  always begin
    @(posedge clk);
    #3;
    for (int i = 0; i < NUM_CH; i++) exp_vec[i] = m_irq[i];
    chk("irq_vec", 32'(irq_vec), 32'(exp_vec));
    chk("interrupt", 32'(interrupt), 32'(|exp_vec));
    chk("ack_valid", 32'(ack_valid), 32'(m_av));
    chk("ack_ch", 32'(ack_ch), m_ach);
  end

  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  task automatic cfg(input int ch, input logic [31:0] pc, input int dly, input int cnt, input bit pulse);
    cfg_ch    = CW'(ch);
    cfg_pc    = pc;
    cfg_delay = DW'(dly);
    cfg_count = CNTW'(cnt);
    cfg_pulse = pulse;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic ack_on(input bit on);
    m_int_addr   = 32'h0000_7f22;
    m_int_byteen = on ? 4'b0100 : 4'b0000;
  endtask

  initial begin
    tick();
    tick();
    chk("reset_irq_vec", 32'(irq_vec), 0);
    chk("reset_ack", 32'({ack_valid, ack_ch}), 0);
    reset = 1'b0;
    en    = 1'b1;

    // Single level channel, delay 0
    cfg(0, 32'h301c, 0, 1, 0);
    macroscopic_pc = 32'h301c;
    tick();
    chk("lvl_fire", 32'(irq_vec), 32'h1);
    chk("lvl_int", 32'(interrupt), 1);
    macroscopic_pc = 32'h0;
    ack_on(1);
    tick();
    chk("lvl_ack_irq", 32'(irq_vec), 0);
    chk("lvl_ack_valid", 32'(ack_valid), 1);
    chk("lvl_ack_ch", 32'(ack_ch), 0);
    ack_on(0);
    tick();
    chk("lvl_ack_once", 32'(ack_valid), 0);
    macroscopic_pc = 32'h301c;
    tick();
    tick();
    chk("lvl_done", 32'(irq_vec), 0);

    // Delay 5, pulse
    cfg(1, 32'h3020, 5, 1, 1);
    macroscopic_pc = 32'h3020;
    tick();
    chk("pulse_k", 32'(irq_vec[1]), 0);
    macroscopic_pc = 32'h0;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk("pulse_wait", 32'(irq_vec[1]), 0);
    end
    tick();
    chk("pulse_hi", 32'(irq_vec[1]), 1);
    tick();
    chk("pulse_lo", 32'(irq_vec[1]), 0);

    // Repeat with rearm, count 3
    cfg(2, 32'h3040, 0, 3, 0);
    for (int f = 0; f < 4; f++) begin
      macroscopic_pc = 32'h3040;
      tick();
      chk("rep_fire", 32'(irq_vec[2]), (f < 3) ? 1 : 0);
      ack_on(1);
      tick();
      chk("rep_ack_irq", 32'(irq_vec[2]), 0);
      chk("rep_ack_valid", 32'(ack_valid), (f < 3) ? 1 : 0);
      ack_on(0);
      if (f == 0) begin
        tick();
        tick();
        chk("rep_held", 32'(irq_vec[2]), 0);
      end
      macroscopic_pc = 32'h0;
      tick();
    end

    // Arbitration ch0 vs ch3
    cfg(0, 32'h3100, 0, 1, 0);
    cfg(3, 32'h3100, 0, 1, 0);
    macroscopic_pc = 32'h3100;
    tick();
    chk("arb_both", 32'(irq_vec), 32'h9);
    ack_on(1);
    tick();
    chk("arb_first", 32'({ack_valid, ack_ch}), 32'h4);
    chk("arb_first_vec", 32'(irq_vec), 32'h8);
    tick();
    chk("arb_second", 32'({ack_valid, ack_ch}), 32'h7);
    tick();
    chk("arb_third", 32'(ack_valid), 0);
    ack_on(0);

    // Config write during WAIT restarts from ARMED
    cfg(1, 32'h3200, 3, 1, 0);
    macroscopic_pc = 32'h3200;
    tick();
    tick();
    macroscopic_pc = 32'h0;
    cfg(1, 32'h3200, 3, 1, 0);
    tick();
    tick();
    tick();
    chk("wait_cfg", 32'(irq_vec), 0);

    // en=0 blocks the match
    cfg(0, 32'h3300, 0, 1, 0);
    en = 1'b0;
    macroscopic_pc = 32'h3300;
    tick();
    tick();
    chk("en_block", 32'(irq_vec), 0);
    en = 1'b1;
    tick();
    chk("en_fire", 32'(irq_vec), 32'h1);

    // Asynchronous reset while in FIRE
    reset = 1'b1;
    #1;
    chk("rst_int", 32'(interrupt), 0);
    chk("rst_vec", 32'(irq_vec), 0);
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_we         = ($urandom_range(0, 9) == 0);
      cfg_ch         = CW'($urandom_range(0, NUM_CH - 1));
      cfg_pc         = 32'h3000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      cfg_delay      = DW'($urandom_range(0, 4));
      cfg_count      = CNTW'($urandom_range(0, 3));
      cfg_pulse      = $urandom_range(0, 1) == 1;
      macroscopic_pc = 32'h3000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      en             = ($urandom_range(0, 7) != 0);
      m_int_addr     = ($urandom_range(0, 5) == 0) ? 32'h7f24 : 32'h7f20 + 32'($urandom_range(0, 3));
      m_int_byteen   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_gen_multi.md
# int_gen_multi

Synthesizable multi-channel interrupt stimulus generator for the pipelined MIPS test environment. It is the parametrised successor of the single-shot bench interrupt generator.
- Each channel watches the CPU's macroscopic PC for a programmable target address.
- On a match it raises an interrupt request after a programmable delay, in level or pulse mode.
- The CPU's store to the interrupt-acknowledge address retires requests.
- Channels re-arm for a programmable number of firings.
- The block sits beside `mips`, driving its `interrupt` input and snooping `m_int_addr`/`m_int_byteen`.

## Interface
- `NUM_CH`, 4: number of channels (1..16).
- `CW`, 2: channel index width, ≥ clog2(NUM_CH), min 1.
- `DW`, 8: delay counter width.
- `CNTW`, 4: firing-count width.
- `ACK_ADDR`, 32'h0000_7f20: word address of the acknowledge register.

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `en`  in  1  global enable for new PC matches.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_ch`  in  CW  channel being configured.
- `cfg_pc`  in  32  target PC; bits [1:0] ignored.
- `cfg_delay`  in  DW  cycles from match to assertion.
- `cfg_count`  in  CNTW  number of firings; 0 disables the channel.
- `cfg_pulse`  in  1  1 = one-cycle pulse, 0 = level held until ack.
- `macroscopic_pc`  in  32  CPU macroscopic PC.
- `m_int_addr`  in  32  CPU interrupt-register store address.
- `m_int_byteen`  in  4  store byte enables.
- `interrupt`  out  1  OR of `irq_vec`.
- `irq_vec`  out  NUM_CH  per-channel request, registered.
- `ack_valid`  out  1  one-cycle flag: an ack retired a channel.
- `ack_ch`  out  CW  channel retired by that ack.

## Operation
- Match condition: `(macroscopic_pc & ~3) == (cfg_pc_reg & ~3)`.
- Ack condition: `|m_int_byteen && (m_int_addr & ~3) == ACK_ADDR`.
- Per-channel states:
  - OFF → ARMED on a config write with `cfg_count` > 0.
  - ARMED → WAIT on match with `en`=1 and delay > 0, loading the counter with the delay.
  - ARMED → FIRE on match with `en`=1 and delay = 0.
  - WAIT decrements each cycle and goes → FIRE when the counter reaches 1.
  - FIRE in level mode holds until an ack selects the channel.
  - FIRE in pulse mode lasts exactly one cycle.
  - Leaving FIRE decrements the remaining count. If the result is > 0 → REARM, else → DONE.
  - REARM → ARMED once the PC fails to match for at least one cycle. This prevents an instant retrigger on the same PC.
  - DONE is terminal until the channel is reconfigured.
- Config write:
  - Overrides the addressed channel's current state and clears its `irq_vec` bit in the same edge.
  - `cfg_count`=0 forces the channel to OFF.
  - `cfg_ch` ≥ NUM_CH is ignored.
- Ack arbitration:
  - An ack retires the lowest-index level-mode channel in FIRE at that edge.
  - Pulse channels are never acked.
  - An ack with no eligible channel has no effect and leaves `ack_valid`=0.
- `en`=0 blocks only ARMED→WAIT/FIRE. WAIT, FIRE and REARM proceed.

## Timing
- Reset values:
  - All channels OFF with config registers zero.
  - `irq_vec`=0, `interrupt`=0, `ack_valid`=0, `ack_ch`=0.
- Match sampled at edge k:
  - delay 0: `irq_vec` bit high after edge k.
  - delay D: `irq_vec` bit high after edge k+D.
- Ack sampled at edge k: the bit falls after edge k, with `ack_valid`=1 and `ack_ch` set for the following cycle only.
- Same-edge ack and new FIRE on another channel: the ack considers only channels already in FIRE before the edge. The new channel stays asserted.
- Same-edge ack and config write on the same channel: the config write wins and `ack_valid`=0.
- `interrupt` is the combinational OR of the registered `irq_vec`, adding zero cycles.
- Reset asserted mid-operation: all outputs go to 0 immediately, asynchronously.

## Structure
- Package `int_gen_pkg` holds:
  - the channel state enum (OFF, ARMED, WAIT, FIRE, REARM, DONE);
  - the default `ACK_ADDR` constant;
  - the PC word-mask constant.
- Sub-module `int_gen_chan` holds one channel's FSM, delay counter, count register and config registers. It exposes `fire_level`, `irq`, and an `ack_sel` input.
- The top instantiates NUM_CH channels and contains the priority ack arbiter plus the `ack_valid`/`ack_ch` registers.

## Test plan
- Single level channel:
  - Setup: ch0, pc 0x301c, delay 0, count 1.
  - Stimulus: PC reaches 0x301c at edge k.
  - Required: `interrupt` high after k. A store to 0x7f22 with byteen 4'b0100 drops it next edge with `ack_ch`=0. The channel ends in DONE.
- Delay and pulse:
  - Setup: ch1, pc 0x3020, delay 5, pulse, count 1.
  - Required: `irq_vec[1]` is high exactly one cycle, after edge k+5. No ack is needed.
- Repeat with rearm:
  - Setup: ch2, count 3, PC held at the target for 4 cycles.
  - Required: a single firing while the PC is held. Two more firings occur only after the PC leaves and returns, each acked. No fourth firing.
- Arbitration:
  - Setup: ch0 and ch3 both level-FIRE.
  - Required: the first ack retires ch0 (`ack_ch`=0) and the second retires ch3. A third ack gives `ack_valid`=0.
- Boundaries:
  - A config write to ch1 during WAIT restarts it from ARMED with no irq.
  - `en`=0 at match blocks firing.
  - Reset asserted while FIRE clears `interrupt` before the next edge.
